// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential Newton-Raphson FP32 divider.
package fp_div_pkg;

  typedef enum logic [3:0] {
    IDLE, SEED_MUL, SEED_ADD, IT_MUL_D, IT_SUB, IT_MUL_X, RECIP, FINAL, DONE
  } fp_div_state_e;

  localparam logic [31:0] SEED_K1  = 32'h3FF0F0F1;
  localparam logic [31:0] SEED_K0  = 32'h4034B4B5;
  localparam logic [31:0] FP_TWO   = 32'h40000000;
  localparam int          NR_ITERS = 3;
  localparam logic [7:0]  EXP_HALF = 8'd126;

  // Leading-zero count of a 27-bit mantissa; 27 when the input is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

endpackage

// File: rtl/FloatingAddition.sv
// Combinational FP32 add (sign-magnitude, GRS rounding to nearest even).
module FloatingAddition
  import fp_div_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);
  logic [31:0] w_big, w_sml;
  logic [7:0]  w_d;
  logic [26:0] w_mb, w_ms, w_shf, w_n;
  logic [53:0] w_wide;
  logic [27:0] w_sum;
  logic [9:0]  w_exp;
  logic [4:0]  w_lz;
  logic        w_rnd;

  always_comb begin
    if (i_a[30:0] >= i_b[30:0]) begin
      w_big = i_a;
      w_sml = i_b;
    end else begin
      w_big = i_b;
      w_sml = i_a;
    end
    w_mb   = {|w_big[30:23], w_big[22:0], 3'b0};
    w_ms   = {|w_sml[30:23], w_sml[22:0], 3'b0};
    w_d    = w_big[30:23] - w_sml[30:23];
    w_wide = {w_ms, 27'b0} >> ((w_d > 8'd27) ? 8'd27 : w_d);
    w_shf  = {w_wide[53:28], w_wide[27] | (|w_wide[26:0])};
    w_sum  = (w_big[31] == w_sml[31]) ? {1'b0, w_mb} + {1'b0, w_shf}
                                       : {1'b0, w_mb} - {1'b0, w_shf};
    w_exp  = {2'b0, w_big[30:23]};
    w_lz   = lzc27(w_sum[26:0]);
    if (w_sum[27]) begin
      w_n   = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp = w_exp + 10'd1;
    end else begin
      w_n   = w_sum[26:0] << w_lz;
      w_exp = w_exp - {5'b0, w_lz};
    end
    w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    if (w_sum == 28'd0) o_result = 32'd0;
    else                o_result = {w_big[31], {w_exp[7:0], w_n[25:3]} + 31'(w_rnd)};
  end
endmodule

// File: rtl/FloatingMultiplication.sv
// Combinational FP32 multiply, normal operands only, round to nearest even.
module FloatingMultiplication (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);
  logic [23:0] w_ma, w_mb;
  logic [47:0] w_p;
  logic [9:0]  w_exp;
  logic [22:0] w_man;
  logic        w_g, w_s, w_rnd;

  always_comb begin
    w_ma  = {1'b1, i_a[22:0]};
    w_mb  = {1'b1, i_b[22:0]};
    w_p   = 48'(w_ma) * 48'(w_mb);
    w_exp = {2'b0, i_a[30:23]} + {2'b0, i_b[30:23]} - 10'd127;
    if (w_p[47]) begin
      w_man = w_p[46:24];
      w_g   = w_p[23];
      w_s   = |w_p[22:0];
      w_exp = w_exp + 10'd1;
    end else begin
      w_man = w_p[45:23];
      w_g   = w_p[22];
      w_s   = |w_p[21:0];
    end
    w_rnd    = w_g & (w_s | w_man[0]);
    // a mantissa carry from rounding ripples into the exponent field
    o_result = {i_a[31] ^ i_b[31], {w_exp[7:0], w_man} + 31'(w_rnd)};
  end
endmodule

// File: rtl/fp_div_opmux.sv
// Steers the shared multiplier/adder operands from the divider registers by state.
module fp_div_opmux
  import fp_div_pkg::*;
(
  input  fp_div_state_e i_state,
  input  logic [31:0]   i_d,
  input  logic [31:0]   i_x,
  input  logic [31:0]   i_t,
  input  logic [31:0]   i_a,
  input  logic [31:0]   i_r,
  output logic [31:0]   o_mul_a,
  output logic [31:0]   o_mul_b,
  output logic [31:0]   o_add_a,
  output logic [31:0]   o_add_b
);
  always_comb begin
    o_mul_a = 32'd0;
    o_mul_b = 32'd0;
    o_add_a = 32'd0;
    o_add_b = 32'd0;
    case (i_state)
      SEED_MUL: begin o_mul_a = i_d; o_mul_b = SEED_K1; end
      // subtraction: the adder sees B with its sign flipped
      SEED_ADD: begin o_add_a = SEED_K0; o_add_b = {~i_t[31], i_t[30:0]}; end
      IT_MUL_D: begin o_mul_a = i_d; o_mul_b = i_x; end
      IT_SUB:   begin o_add_a = FP_TWO;  o_add_b = {~i_t[31], i_t[30:0]}; end
      IT_MUL_X: begin o_mul_a = i_x; o_mul_b = i_t; end
      FINAL:    begin o_mul_a = i_a; o_mul_b = i_r; end
      default:  ;
    endcase
  end
endmodule

// File: rtl/fp_div_seq.sv
// Sequential FP32 divider: Newton-Raphson reciprocal of the scaled divisor, then a*r.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero,
  output logic            busy
);
  fp_div_state_e   r_state, w_nxt;
  logic [XLEN-1:0] r_a, r_b, r_result;
  logic [31:0]     r_x, r_t, r_r;
  logic [1:0]      r_cnt;
  logic            r_dbz;
  logic [31:0]     w_d, w_mul_a, w_mul_b, w_add_a, w_add_b, w_mul, w_add;
  logic            w_last;

  // divisor mantissa rescaled into [0.5, 1); the exponent is restored in RECIP
  assign w_d    = {1'b0, EXP_HALF, r_b[22:0]};
  assign w_last = (r_cnt == 2'(NR_ITERS - 1));

  fp_div_opmux u_opmux (
    .i_state (r_state), .i_d (w_d), .i_x (r_x), .i_t (r_t), .i_a (r_a), .i_r (r_r),
    .o_mul_a (w_mul_a), .o_mul_b (w_mul_b), .o_add_a (w_add_a), .o_add_b (w_add_b)
  );

  FloatingMultiplication u_mul (.i_a (w_mul_a), .i_b (w_mul_b), .o_result (w_mul));
  FloatingAddition       u_add (.i_a (w_add_a), .i_b (w_add_b), .o_result (w_add));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     if (in_valid) w_nxt = SEED_MUL;
      SEED_MUL: w_nxt = (r_b[30:23] == 8'd0 || r_a[30:23] == 8'd0) ? DONE : SEED_ADD;
      SEED_ADD: w_nxt = IT_MUL_D;
      IT_MUL_D: w_nxt = IT_SUB;
      IT_SUB:   w_nxt = IT_MUL_X;
      IT_MUL_X: w_nxt = w_last ? RECIP : IT_MUL_D;
      RECIP:    w_nxt = FINAL;
      FINAL:    w_nxt = DONE;
      DONE:     if (out_ready) w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_t      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a   <= a;
          r_b   <= b;
          r_cnt <= '0;
        end
        SEED_MUL: begin
          // zero divisor wins over zero dividend, so 0/0 flags div_by_zero
          if (r_b[30:23] == 8'd0) begin
            r_result <= {r_a[31] ^ r_b[31], 8'hFF, 23'h0};
            r_dbz    <= 1'b1;
          end else if (r_a[30:23] == 8'd0) begin
            r_result <= {r_a[31] ^ r_b[31], 31'h0};
            r_dbz    <= 1'b0;
          end
          r_t <= w_mul;
        end
        SEED_ADD: r_x <= w_add;
        IT_MUL_D: r_t <= w_mul;
        IT_SUB:   r_t <= w_add;
        IT_MUL_X: begin
          r_x   <= w_mul;
          r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
        end
        RECIP:    r_r <= {r_b[31], r_x[30:23] + EXP_HALF - r_b[30:23], r_x[22:0]};
        FINAL: begin
          r_result <= w_mul;
          r_dbz    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign out_valid   = (r_state == DONE);
  assign result      = r_result;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_fp_div_seq.sv
// Randomized bench for fp_div_seq against a real-arithmetic quotient model.
module tb_fp_div_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        div_by_zero;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  fp_div_seq #(.XLEN(32)) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .a (a), .b (b), .out_valid (out_valid), .out_ready (out_ready),
    .result (result), .div_by_zero (div_by_zero), .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp,
                     input int tol = 0);
    longint d;
    n_vec++;
    d = longint'(got) - longint'(exp);
    if (d < 0) d = -d;
    if ($isunknown(got) || got[31] !== exp[31] || d > longint'(tol)) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h tol=%0d", tag, got, exp, tol);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [7:0]  e;
    logic        rnd;
    d   = $realtobits(r);
    e   = 8'(int'(d[62:52]) - 896);
    rnd = d[28] & ((|d[27:0]) | d[29]);
    return {d[63], {e, d[51:29]} + 31'(rnd)};
  endfunction

  // Reference: specials by exponent field, otherwise correctly rounded a/b.
  task automatic model(input logic [31:0] ta, tb, output logic [31:0] q,
                       output logic dbz, output int lat);
    dbz = 1'b0;
    lat = 1;
    if (tb[30:23] == 8'd0) begin
      q = {ta[31] ^ tb[31], 8'hFF, 23'h0};
      dbz = 1'b1;
    end else if (ta[30:23] == 8'd0) begin
      q = {ta[31] ^ tb[31], 31'h0};
    end else begin
      q = r2f(f2r(ta) / f2r(tb));
      lat = 13;
    end
  endtask

  task automatic run_op(input logic [31:0] ta, tb, input logic [31:0] eq,
                        input int tol, input logic edbz, input int elat, input int stall);
    int w, lat;
    bit got;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 10) begin @(negedge clk); w++; end
    chk("in_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy", 32'(busy), 32'd1);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      a = $urandom; b = $urandom;
      @(posedge clk); lat++; #1;
      got = out_valid;
    end
    chk("timeout", 32'(got), 32'd1);
    if (!got) return;
    chk("latency", 32'(lat), 32'(elat));
    chk("quot", result, eq, tol);
    chk("dbz", 32'(div_by_zero), 32'(edbz));
    if (stall > 0) begin
      in_valid = 1'b1;
      repeat (stall) begin
        @(posedge clk); #1;
        chk("hold_v", 32'(out_valid), 32'd1);
        chk("hold_q", result, eq, tol);
        chk("hold_dbz", 32'(div_by_zero), 32'(edbz));
        chk("no_accept", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid", 32'(out_valid), 32'd0);
    chk("hs_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_rand(input logic [31:0] ta, tb);
    logic [31:0] q;
    logic dbz;
    int lat;
    model(ta, tb, q, dbz, lat);
    run_op(ta, tb, q, (lat == 1) ? 0 : 3, dbz, lat, 0);
  endtask

  function automatic logic [31:0] rnd_norm();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_op(32'h3F800000, 32'h40000000, 32'h3F000000, 1, 1'b0, 13, 0);
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 1, 1'b0, 13, 0);
    run_op(32'hC0F00000, 32'h40200000, 32'hC0400000, 1, 1'b0, 13, 0);
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 0, 1'b1, 1, 0);
    run_op(32'h00000000, 32'h40000000, 32'h00000000, 0, 1'b0, 1, 0);
    run_op(32'h00000000, 32'h80000000, 32'hFF800000, 0, 1'b1, 1, 0);
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 1, 1'b0, 13, 5);

    // reset mid-operation discards the in-flight division
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    rst = 1'b0;
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 1, 1'b0, 13, 0);

    for (int i = 0; i < 40; i++) run_rand(rnd_norm(), rnd_norm());
    for (int i = 0; i < 4; i++)
      run_rand(rnd_norm(), {1'($urandom), 8'h00, 23'($urandom)});
    for (int i = 0; i < 4; i++)
      run_rand({1'($urandom), 8'h00, 23'($urandom)}, rnd_norm());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  dividend/divisor pair offered.
REQ-005 in_ready  out  1  block can accept a pair.
REQ-006 a  in  XLEN  dividend.
REQ-007 b  in  XLEN  divisor.
REQ-008 out_valid  out  1  result available.
REQ-009 out_ready  in  1  consumer takes result.
REQ-010 result  out  XLEN  quotient a/b.
REQ-011 div_by_zero  out  1  divisor exponent field was zero; qualified by out_valid.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL compute a/b by Newton-Raphson reciprocal, time-sharing one multiplier and one adder, one arithmetic operation per cycle.
REQ-014 The FSM SHALL have states: IDLE, SEED_MUL, SEED_ADD, IT_MUL_D, IT_SUB, IT_MUL_X, RECIP, FINAL, DONE.
REQ-015 Accept occurs on the edge where in_valid && in_ready; a and b are then registered, and later changes to a and b are ignored.
REQ-016 in_ready SHALL be high only in IDLE; there is no same-cycle accept in DONE.
REQ-017 Scaled divisor D = {0, 8'd126, b[22:0]} (range [0.5, 1)).
REQ-018 SEED_MUL: t = D*32'h3FF0F0F1; SEED_ADD: x = 32'h4034B4B5 - t.
REQ-019 Iteration: IT_MUL_D: t = D*x; IT_SUB: t = 32'h40000000 - t; IT_MUL_X: x = x*t.
REQ-020 A 2-bit counter SHALL run exactly 3 iterations; after the third IT_MUL_X the FSM goes to RECIP, otherwise back to IT_MUL_D.
REQ-021 RECIP: r = {b[31], x[30:23] + 8'd126 - b[30:23], x[22:0]}, with 8-bit wrap arithmetic.
REQ-022 FINAL: result register = a*r; FSM goes to DONE with out_valid high.
REQ-023 Normal latency SHALL be exactly 13 cycles: out_valid is first high after the 13th rising edge following the accept edge.
REQ-024 If b[30:23]==0: skip the iteration and go to DONE after 1 cycle with result={a[31]^b[31], 8'hFF, 23'h0} and div_by_zero=1.
REQ-025 Else if a[30:23]==0: go to DONE after 1 cycle with result={a[31]^b[31], 31'h0} and div_by_zero=0.
REQ-026 The b-zero check takes priority over the a-zero check (0/0 reports div_by_zero).
REQ-027 In DONE, result and div_by_zero SHALL hold stable while out_valid && !out_ready.
REQ-028 On out_valid && out_ready the FSM SHALL go to IDLE; out_valid drops and in_ready rises on the next cycle.
REQ-029 Overflow, underflow, NaN and denormal inputs (other than the zero-exponent rules) are not handled; the result is as computed.

Reset
REQ-030 rst SHALL put the FSM in IDLE, clear the counter, and set out_valid=0, div_by_zero=0, result=0, busy=0, in_ready=1 by the next edge.
REQ-031 rst SHALL win over every other event, including mid-operation and in DONE awaiting out_ready; the in-flight operation is discarded.

Structure
REQ-032 Package fp_div_pkg SHALL hold the FSM state enum and the constants SEED_K1=32'h3FF0F0F1, SEED_K0=32'h4034B4B5, FP_TWO=32'h40000000, NR_ITERS=3, EXP_HALF=8'd126.
REQ-033 The block SHALL instantiate exactly one FloatingMultiplication and one FloatingAddition, with operands driven from state-selected registers (subtraction = adder with sign-flipped B).
REQ-034 The operand-select logic SHALL be one sub-module, fp_div_opmux: state plus registers in, mul/add operands out.

Verification
REQ-035 a=3F800000, b=40000000, out_ready=1 -> result 3F000000 (±1 ulp) at 13 cycles, div_by_zero=0.
REQ-036 a=40C00000, b=40400000 -> 40000000 (±1 ulp); a=C0F00000, b=40200000 -> C0400000 (±1 ulp).
REQ-037 a=3F800000, b=00000000 -> 7F800000 with div_by_zero=1 after 1 cycle; a=00000000, b=40000000 -> 00000000 after 1 cycle.
REQ-038 out_ready low for 5 cycles in DONE -> result/out_valid stable; a new in_valid is not accepted until the cycle after the handshake.
REQ-039 rst pulsed 6 cycles after accept -> out_valid=0 and in_ready=1 after the reset edge; the next division completes correctly in 13 cycles.
REQ-040 Back-to-back operations with a and b changing while busy -> each result matches the operands captured at its accept.
